pc_seq: RTL and testbench

//  Program-counter sequencer: the consumer side of the jump-offset lookup table.

---
 rtl/pc_seq_if.sv | 29 ++
 rtl/pc_seq.sv | 109 ++++++++++
 tb/tb_pc_seq.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pc_seq_if.sv
// rtl/pc_seq_if.sv - request/status bundle between the sequencer and its decoder/LUT
// Requests flow master->slave; PC and status flow back.
interface pc_seq_if #(
  parameter int PC_W = 10
);
  logic            start;
  logic            stall;
  logic            halt;
  logic            branch_en;
  logic [7:0]      offset;
  logic            jump_en;
  logic [PC_W-1:0] target;
  logic            call_en;
  logic            ret_en;
  logic [PC_W-1:0] pc;
  logic            running;
  logic            done;
  logic [PC_W-1:0] link;

  modport master (
    output start, stall, halt, branch_en, offset, jump_en, target, call_en, ret_en,
    input  pc, running, done, link
  );

  modport slave (
    input  start, stall, halt, branch_en, offset, jump_en, target, call_en, ret_en,
    output pc, running, done, link
  );
endinterface

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - program-counter sequencer with IDLE/RUN/HALT control
// Optional single-entry call/return link register enabled by macro PC_LINK_EN.
module pc_seq #(
  parameter int          PC_W       = 10,
  parameter int unsigned START_ADDR = 0
) (
  input  logic    i_clk,
  input  logic    i_reset,
  pc_seq_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;
  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  logic [1:0]      r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_running;
  logic            r_done;
  logic [1:0]      w_state_next;
  logic [PC_W-1:0] w_pc_next;
  logic [PC_W-1:0] w_pc_rel;
  logic [PC_W-1:0] w_pc_inc;

  // Offset is sign-extended; the sum wraps naturally modulo 2**PC_W.
  assign w_pc_rel = r_pc + PC_W'(signed'(bus.offset));
  assign w_pc_inc = r_pc + PC_W'(1);

`ifdef PC_LINK_EN
  logic [PC_W-1:0] r_link;
  logic [PC_W-1:0] w_link_next;
`else
  logic w_unused_link_req;
  assign w_unused_link_req = bus.call_en ^ bus.ret_en;
`endif

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
`ifdef PC_LINK_EN
    w_link_next  = r_link;
`endif
    case (r_state)
      S_IDLE, S_HALT: begin
        if (bus.start) begin
          w_state_next = S_RUN;
          w_pc_next    = START_PC;
        end
      end
      S_RUN: begin
        if (bus.halt) begin
          w_state_next = S_HALT;
        end else if (bus.stall) begin
          w_pc_next = r_pc;
`ifdef PC_LINK_EN
        end else if (bus.ret_en) begin
          w_pc_next = r_link;
`endif
        end else if (bus.jump_en) begin
          w_pc_next = bus.target;
`ifdef PC_LINK_EN
        end else if (bus.call_en) begin
          w_pc_next   = w_pc_rel;
          w_link_next = w_pc_inc;
`endif
        end else if (bus.branch_en) begin
          w_pc_next = w_pc_rel;
        end else begin
          w_pc_next = w_pc_inc;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_pc_next    = START_PC;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_pc      <= START_PC;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pc      <= w_pc_next;
      r_running <= (w_state_next == S_RUN);
      r_done    <= (w_state_next == S_HALT);
    end
  end

`ifdef PC_LINK_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_link <= '0;
    end else begin
      r_link <= w_link_next;
    end
  end
  assign bus.link = r_link;
`else
  assign bus.link = '0;
`endif

  assign bus.pc      = r_pc;
  assign bus.running = r_running;
  assign bus.done    = r_done;
endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - directed self-checking bench for pc_seq (PC_W=10, START_ADDR=0)
// Link expectations follow macro PC_LINK_EN.
module tb_pc_seq;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  pc_seq_if #(.PC_W(10)) bus ();

  pc_seq #(.PC_W(10), .START_ADDR(0)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int pc, input bit run, input bit dn);
    chk({tag, ".pc"}, 32'(bus.pc), 32'(pc));
    chk({tag, ".running"}, 32'(bus.running), 32'(run));
    chk({tag, ".done"}, 32'(bus.done), 32'(dn));
  endtask

  task automatic clear_reqs();
    bus.start = 0; bus.stall = 0; bus.halt = 0; bus.branch_en = 0;
    bus.offset = '0; bus.jump_en = 0; bus.target = '0; bus.call_en = 0; bus.ret_en = 0;
  endtask

  task automatic jump_to(input int addr);
    bus.jump_en = 1; bus.target = 10'(addr);
    tick();
    bus.jump_en = 0;
  endtask

  initial begin
    clear_reqs();
    rst = 1;
    tick(); tick();
    chk_state("reset", 0, 0, 0);
    chk("reset.link", 32'(bus.link), 0);

    rst = 0;
    bus.start = 1;
    chk_state("pre_start", 0, 0, 0);
    tick();
    bus.start = 0;
    chk_state("start", 0, 1, 0);
    tick(); chk("inc1", 32'(bus.pc), 1);
    tick(); chk("inc2", 32'(bus.pc), 2);
    tick(); chk("inc3", 32'(bus.pc), 3);

    jump_to(20);
    chk("jump20", 32'(bus.pc), 20);
    bus.branch_en = 1; bus.offset = 8'hF5;
    tick(); chk("branch_m11", 32'(bus.pc), 9);
    bus.offset = 8'h06;
    tick(); chk("branch_p6", 32'(bus.pc), 15);
    bus.branch_en = 0;

    jump_to(3);
    bus.branch_en = 1; bus.offset = 8'hEE;
    tick(); chk("wrap_back", 32'(bus.pc), 1009);
    bus.branch_en = 0;
    jump_to(1023);
    chk("jump_top", 32'(bus.pc), 1023);
    tick(); chk("wrap_fwd", 32'(bus.pc), 0);
    bus.branch_en = 1; bus.offset = 8'h00;
    tick(); chk("self_loop", 32'(bus.pc), 0);
    bus.branch_en = 0;

    bus.jump_en = 1; bus.branch_en = 1; bus.offset = 8'h04; bus.target = 10'd5;
    tick(); chk("jump_over_branch", 32'(bus.pc), 5);
    bus.jump_en = 0;
    bus.stall = 1;
    tick(); chk_state("stall", 5, 1, 0);
    bus.stall = 0; bus.branch_en = 0;

    bus.halt = 1; bus.jump_en = 1; bus.target = 10'd100;
    tick(); chk_state("halt", 5, 0, 1);
    bus.halt = 0; bus.branch_en = 1; bus.offset = 8'h10; bus.stall = 1;
    tick(); chk_state("halt_ignore", 5, 0, 1);
    clear_reqs();

    bus.start = 1;
    tick(); chk_state("restart", 0, 1, 0);
    tick(); chk("start_in_run", 32'(bus.pc), 1);
    bus.start = 0;

    jump_to(40);
    chk("jump40", 32'(bus.pc), 40);
    rst = 1; bus.start = 1;
    tick(); chk_state("reset_mid_run", 0, 0, 0);
    rst = 0; bus.start = 0; bus.jump_en = 1; bus.target = 10'd77;
    tick(); chk_state("idle_ignore", 0, 0, 0);
    bus.jump_en = 0;

    bus.start = 1;
    tick(); bus.start = 0;
    chk_state("link_start", 0, 1, 0);
    jump_to(12);
    bus.call_en = 1; bus.offset = 8'h05;
    tick();
`ifdef PC_LINK_EN
    chk("call.pc", 32'(bus.pc), 17);
    chk("call.link", 32'(bus.link), 13);
`else
    chk("call.pc", 32'(bus.pc), 13);
    chk("call.link", 32'(bus.link), 0);
`endif
    bus.call_en = 0; bus.ret_en = 1;
    tick();
`ifdef PC_LINK_EN
    chk("ret.pc", 32'(bus.pc), 13);
    chk("ret.link", 32'(bus.link), 13);
`else
    chk("ret.pc", 32'(bus.pc), 14);
    chk("ret.link", 32'(bus.link), 0);
`endif
    bus.call_en = 1; bus.offset = 8'h20;
    tick();
`ifdef PC_LINK_EN
    chk("call_ret.pc", 32'(bus.pc), 13);
    chk("call_ret.link", 32'(bus.link), 13);
`else
    chk("call_ret.pc", 32'(bus.pc), 15);
    chk("call_ret.link", 32'(bus.link), 0);
`endif
    clear_reqs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
